// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative radix-2 shift-add MUL/MLA unit feeding register file write port 3
module mul_iter_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              acc,
  input  logic [WIDTH-1:0]  Rm,
  input  logic [WIDTH-1:0]  Rs,
  input  logic [WIDTH-1:0]  Rn,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              ack,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [WIDTH-1:0]  write_data
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0]  mcand, mplier, accum, accum_nx, mplier_nx;
  logic [ADDR_W-1:0] addr;
  logic [IW-1:0]     iter;
  logic              done;
  assign mplier_nx = mplier >> 1;
  assign accum_nx  = mplier[0] ? accum + mcand : accum;
  // the last iteration is the one whose increment wraps iter back to zero
  assign done = (iter == IW'(WIDTH - 1)) || (EARLY_TERM != 0 && mplier_nx == '0);
  assign busy         = state != IDLE;
  assign ack          = state == WB;
  assign write_enable = state == WB;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req ? MUL : IDLE) : state == MUL ? (done ? WB : MUL) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand         <= '0;
      mplier        <= '0;
      accum         <= '0;
      addr          <= '0;
      iter          <= '0;
      write_data    <= '0;
      write_address <= '0;
    end else if (state == IDLE && req) begin
      mcand  <= Rm;
      mplier <= Rs;
      accum  <= acc ? Rn : '0;
      addr   <= dest_addr;
      iter   <= '0;
    end else if (state == MUL) begin
      accum  <= accum_nx;
      mcand  <= mcand << 1;
      mplier <= mplier_nx;
      iter   <= iter + 1'b1;
      // outputs only change on completion so they hold the previous result during MUL
      if (done) begin
        write_data    <= accum_nx;
        write_address <= addr;
      end
    end
endmodule
